alu_mdu_seq: RTL and testbench

//   Parametrised sequential integer execute unit for the RV32IM pipeline.
//   - Keeps the single-cycle base ALU op set and adds the M-extension (MUL*/DIV*/REM*).
//   - Operations are accepted through a valid/ready handshake.
//   - Result and flags leave through a registered output with a one-cycle valid pulse.
//   - EX stage stalls on IN_READY=0 while a multicycle op runs.

---
 rtl/alu_mdu_seq.sv | 191 +++++++++++++++++++
 tb/tb_alu_mdu_seq.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mdu_seq.sv
// alu_mdu_seq: RV32IM execute unit; 1-cycle ALU, 2-cycle MUL, XLEN+2-cycle restoring DIV.
// IN_READY drops while MUL/DIV is busy; OUT_VALID is a one-cycle pulse with no back-pressure.
module alu_mdu_seq #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 5
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            IN_VALID,
  output logic            IN_READY,
  input  logic [XLEN-1:0] OP1,
  input  logic [XLEN-1:0] OP2,
  input  logic [4:0]      ALU_OP,
  input  logic            FLUSH,
  output logic            OUT_VALID,
  output logic [XLEN-1:0] RESULT,
  output logic            ZERO,
  output logic            SIGN_BIT,
  output logic            SLTU_BIT
);

  localparam int CW = SHAMT_W + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(XLEN);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [1:0]        op_q, op_d;
  logic [XLEN-1:0]   a_q, a_d, b_q, b_d;
  logic [XLEN-1:0]   rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic              out_valid_q, out_valid_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              sltu_q, sltu_d;

  logic [SHAMT_W-1:0] shamt;
  logic [XLEN-1:0]    alu_res;
  logic               in_mul, in_div, op1_neg, op2_neg, accept;
  logic               m_sa, m_sb;
  logic [2*XLEN-1:0]  pa, pb, prod;
  logic [XLEN-1:0]    mul_res;
  logic [XLEN:0]      sh, diff;
  logic               d_an, d_bn;
  logic [XLEN-1:0]    q_fix, r_fix, div_res;

  assign shamt = OP2[SHAMT_W-1:0];

  always_comb begin
    alu_res = '0;
    case (ALU_OP)
      5'd0:  alu_res = OP1 + OP2;
      5'd1:  alu_res = OP1 << shamt;
      5'd2:  alu_res = {{(XLEN-1){1'b0}}, ($signed(OP1) < $signed(OP2))};
      5'd3:  alu_res = {{(XLEN-1){1'b0}}, (OP1 < OP2)};
      5'd4:  alu_res = OP1 ^ OP2;
      5'd5:  alu_res = OP1 >> shamt;
      5'd13: alu_res = $unsigned($signed(OP1) >>> shamt);
      5'd6:  alu_res = OP1 | OP2;
      5'd7:  alu_res = OP1 & OP2;
      5'd16: alu_res = OP2;
      default: alu_res = '0;
    endcase
  end

  assign in_mul   = (ALU_OP[4:2] == 3'b101);
  assign in_div   = (ALU_OP[4:2] == 3'b110);
  assign op1_neg  = ~ALU_OP[0] & OP1[XLEN-1];
  assign op2_neg  = ~ALU_OP[0] & OP2[XLEN-1];
  assign IN_READY = (state_q == S_IDLE);
  assign accept   = IN_VALID & IN_READY & ~FLUSH;

  // MULH and MULHSU treat OP1 as signed; only MULH treats OP2 as signed.
  assign m_sa    = (op_q == 2'b01) || (op_q == 2'b10);
  assign m_sb    = (op_q == 2'b01);
  assign pa      = {{XLEN{m_sa & a_q[XLEN-1]}}, a_q};
  assign pb      = {{XLEN{m_sb & b_q[XLEN-1]}}, b_q};
  assign prod    = pa * pb;
  assign mul_res = (op_q == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

  // Restoring step: a clear borrow bit means the shifted remainder covers the divisor.
  assign sh   = {rem_q, quo_q[XLEN-1]};
  assign diff = sh - {1'b0, dvs_q};

  assign d_an    = ~op_q[0] & a_q[XLEN-1];
  assign d_bn    = ~op_q[0] & b_q[XLEN-1];
  assign q_fix   = (b_q == '0) ? '1  : ((d_an ^ d_bn) ? -quo_q : quo_q);
  assign r_fix   = (b_q == '0) ? a_q : (d_an ? -rem_q : rem_q);
  assign div_res = op_q[1] ? r_fix : q_fix;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    out_valid_d = 1'b0;
    result_d    = result_q;
    sltu_d      = sltu_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d = ALU_OP[1:0];
          a_d  = OP1;
          b_d  = OP2;
          if (in_mul) begin
            state_d = S_MUL;
          end else if (in_div) begin
            state_d = S_DIV;
            cnt_d   = '0;
            rem_d   = '0;
            quo_d   = op1_neg ? -OP1 : OP1;
            dvs_d   = op2_neg ? -OP2 : OP2;
          end else begin
            out_valid_d = 1'b1;
            result_d    = alu_res;
            sltu_d      = (OP1 < OP2);
          end
        end
      end
      S_MUL: begin
        out_valid_d = 1'b1;
        result_d    = mul_res;
        sltu_d      = (a_q < b_q);
        state_d     = S_IDLE;
      end
      S_DIV: begin
        if (cnt_q == CNT_LAST) begin
          out_valid_d = 1'b1;
          result_d    = div_res;
          sltu_d      = (a_q < b_q);
          state_d     = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (!diff[XLEN]) begin
            rem_d = diff[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], 1'b1};
          end else begin
            rem_d = sh[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], 1'b0};
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A flush beats a completing op in the same cycle.
    if (FLUSH) begin
      state_d     = S_IDLE;
      out_valid_d = 1'b0;
      result_d    = result_q;
      sltu_d      = sltu_q;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      sltu_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      sltu_q      <= sltu_d;
    end
  end

  assign OUT_VALID = out_valid_q;
  assign RESULT    = result_q;
  assign ZERO      = (result_q == '0);
  assign SIGN_BIT  = result_q[XLEN-1];
  assign SLTU_BIT  = sltu_q;

endmodule

// File: tb/tb_alu_mdu_seq.sv
// Bench for alu_mdu_seq: vector table, directed corner sequences, random ops vs an arithmetic model.
module tb_alu_mdu_seq;
  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        IN_VALID = 1'b0;
  logic        FLUSH = 1'b0;
  logic [31:0] OP1 = '0;
  logic [31:0] OP2 = '0;
  logic [4:0]  ALU_OP = '0;
  logic        IN_READY, OUT_VALID, ZERO, SIGN_BIT, SLTU_BIT;
  logic [31:0] RESULT;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat;
  } vec_t;
  vec_t tbl[$];

  always #5 CLK = ~CLK;

  alu_mdu_seq #(.XLEN(32), .SHAMT_W(5)) dut (
    .CLK(CLK), .RESET(RESET), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .OP1(OP1), .OP2(OP2), .ALU_OP(ALU_OP), .FLUSH(FLUSH),
    .OUT_VALID(OUT_VALID), .RESULT(RESULT), .ZERO(ZERO),
    .SIGN_BIT(SIGN_BIT), .SLTU_BIT(SLTU_BIT)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  function automatic void model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output int lat);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    r = '0;
    lat = 1;
    case (op)
      5'd0:  r = a + b;
      5'd1:  r = a << b[4:0];
      5'd2:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      5'd3:  r = (a < b) ? 32'd1 : 32'd0;
      5'd4:  r = a ^ b;
      5'd5:  r = a >> b[4:0];
      5'd13: r = $unsigned($signed(a) >>> b[4:0]);
      5'd6:  r = a | b;
      5'd7:  r = a & b;
      5'd16: r = b;
      5'd20: begin p = sa * sb; r = p[31:0];  lat = 2; end
      5'd21: begin p = sa * sb; r = p[63:32]; lat = 2; end
      5'd22: begin p = sa * ub; r = p[63:32]; lat = 2; end
      5'd23: begin p = ua * ub; r = p[63:32]; lat = 2; end
      5'd24: begin lat = 34; if (b == 0) r = '1; else begin p = sa / sb; r = p[31:0]; end end
      5'd25: begin lat = 34; if (b == 0) r = '1; else r = a / b; end
      5'd26: begin lat = 34; if (b == 0) r = a;  else begin p = sa % sb; r = p[31:0]; end end
      5'd27: begin lat = 34; if (b == 0) r = a;  else r = a % b; end
      default: r = '0;
    endcase
  endfunction

  task automatic add_vec(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input int lat);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.res = res; v.lat = lat;
    tbl.push_back(v);
  endtask

  // Issues one op, scrambles the operand inputs while busy, and checks latency, ready and outputs.
  task automatic run_op(input string nm, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] er, input int elat);
    int w = 0;
    int lat;
    while (!IN_READY && w < 60) begin step(); w++; end
    chk({nm, "_rdy_in"}, IN_READY, 1);
    IN_VALID = 1'b1; ALU_OP = op; OP1 = a; OP2 = b;
    step();
    IN_VALID = 1'b0; ALU_OP = 5'($urandom); OP1 = $urandom; OP2 = $urandom;
    lat = 1;
    while (!OUT_VALID && lat < 60) begin
      chk({nm, "_busy"}, IN_READY, 0);
      step();
      lat++;
    end
    chk({nm, "_lat"}, lat, elat);
    chk({nm, "_res"}, RESULT, er);
    chk({nm, "_zero"}, ZERO, (er == 0));
    chk({nm, "_sign"}, SIGN_BIT, er[31]);
    chk({nm, "_sltu"}, SLTU_BIT, (a < b));
    chk({nm, "_rdy_out"}, IN_READY, 1);
  endtask

  task automatic no_stray(input string nm, input int n);
    int stray = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (OUT_VALID) stray++;
    end
    chk(nm, stray, 0);
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] specials [4];
    specials[0] = 32'h8000_0000; specials[1] = 32'hFFFF_FFFF;
    specials[2] = 32'h0;         specials[3] = 32'h1;
    case ($urandom_range(0, 3))
      0: return $urandom;
      1: return 32'($urandom_range(0, 15));
      2: return specials[$urandom_range(0, 3)];
      default: return -32'($urandom_range(1, 15));
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0]  ops [20];
    logic [31:0] r, a, b;
    logic [4:0]  op;
    int          lat;

    ops = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd13, 5'd6, 5'd7, 5'd16,
            5'd20, 5'd21, 5'd22, 5'd23, 5'd24, 5'd25, 5'd26, 5'd27, 5'd9, 5'd31};

    add_vec(5'd0,  32'd5,        32'd7,        32'd12,       1);
    add_vec(5'd1,  32'd1,        32'h21,       32'd2,        1);
    add_vec(5'd2,  32'hFFFFFFFF, 32'd1,        32'd1,        1);
    add_vec(5'd3,  32'hFFFFFFFF, 32'd1,        32'd0,        1);
    add_vec(5'd4,  32'hF0F0,     32'hFF00,     32'h0FF0,     1);
    add_vec(5'd5,  32'h80000000, 32'h3F,       32'd1,        1);
    add_vec(5'd13, 32'h80000000, 32'd4,        32'hF8000000, 1);
    add_vec(5'd6,  32'hF0,       32'h0F,       32'hFF,       1);
    add_vec(5'd7,  32'hF0,       32'h3C,       32'h30,       1);
    add_vec(5'd16, 32'h1234,     32'hDEAD,     32'hDEAD,     1);
    add_vec(5'd9,  32'h1234,     32'h5678,     32'h0,        1);
    add_vec(5'd20, 32'd7,        32'd6,        32'd42,       2);
    add_vec(5'd21, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        2);
    add_vec(5'd23, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 2);
    add_vec(5'd22, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 2);
    add_vec(5'd24, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34);
    add_vec(5'd26, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34);
    add_vec(5'd25, 32'd1234,     32'd0,        32'hFFFFFFFF, 34);
    add_vec(5'd27, 32'd1234,     32'd0,        32'd1234,     34);
    add_vec(5'd24, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF, 34);
    add_vec(5'd24, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 34);
    add_vec(5'd26, 32'h80000000, 32'hFFFFFFFF, 32'h0,        34);
    add_vec(5'd25, 32'd100,      32'd7,        32'd14,       34);
    add_vec(5'd27, 32'd100,      32'd7,        32'd2,        34);

    // Reset values, held while RESET is low.
    step(); step();
    chk("rst_ready", IN_READY, 1);
    chk("rst_valid", OUT_VALID, 0);
    chk("rst_result", RESULT, 0);
    chk("rst_zero", ZERO, 1);
    chk("rst_sign", SIGN_BIT, 0);
    chk("rst_sltu", SLTU_BIT, 0);
    RESET = 1'b1;
    step();

    foreach (tbl[i]) run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].lat);

    // Three single-cycle ops streamed back to back.
    IN_VALID = 1'b1; ALU_OP = 5'd0; OP1 = 32'd1; OP2 = 32'hFFFFFFFF;
    step();
    chk("str0_valid", OUT_VALID, 1); chk("str0_res", RESULT, 0); chk("str0_zero", ZERO, 1);
    ALU_OP = 5'd13; OP1 = 32'h80000000; OP2 = 32'd4;
    step();
    chk("str1_valid", OUT_VALID, 1); chk("str1_res", RESULT, 32'hF8000000); chk("str1_sign", SIGN_BIT, 1);
    ALU_OP = 5'd3; OP1 = 32'd1; OP2 = 32'd2;
    step();
    chk("str2_valid", OUT_VALID, 1); chk("str2_res", RESULT, 1); chk("str2_sltu", SLTU_BIT, 1);
    IN_VALID = 1'b0;
    step();
    chk("str_pulse", OUT_VALID, 0); chk("str_hold", RESULT, 1);

    // Flush in IDLE drops the op presented alongside it.
    FLUSH = 1'b1; IN_VALID = 1'b1; ALU_OP = 5'd0; OP1 = 32'd3; OP2 = 32'd4;
    step();
    FLUSH = 1'b0; IN_VALID = 1'b0;
    chk("fl_idle_valid", OUT_VALID, 0); chk("fl_idle_hold", RESULT, 1);
    no_stray("fl_idle_stray", 3);

    // Flush at cycle 10 of a DIV, then an AND one cycle later.
    IN_VALID = 1'b1; ALU_OP = 5'd24; OP1 = 32'd1000; OP2 = 32'd7;
    step();
    IN_VALID = 1'b0;
    for (int i = 0; i < 9; i++) step();
    FLUSH = 1'b1;
    step();
    FLUSH = 1'b0;
    chk("fl_div_ready", IN_READY, 1); chk("fl_div_valid", OUT_VALID, 0);
    IN_VALID = 1'b1; ALU_OP = 5'd7; OP1 = 32'hF0; OP2 = 32'h3C;
    step();
    IN_VALID = 1'b0;
    chk("fl_and_valid", OUT_VALID, 1); chk("fl_and_res", RESULT, 32'h30);
    no_stray("fl_div_stray", 40);

    // Flush in the final DIV cycle beats completion.
    IN_VALID = 1'b1; ALU_OP = 5'd25; OP1 = 32'd100; OP2 = 32'd7;
    step();
    IN_VALID = 1'b0;
    for (int i = 0; i < 32; i++) step();
    chk("fl_last_busy", IN_READY, 0);
    FLUSH = 1'b1;
    step();
    FLUSH = 1'b0;
    chk("fl_last_valid", OUT_VALID, 0); chk("fl_last_hold", RESULT, 32'h30);
    chk("fl_last_ready", IN_READY, 1);
    no_stray("fl_last_stray", 5);

    // Flush during MUL.
    IN_VALID = 1'b1; ALU_OP = 5'd20; OP1 = 32'd9; OP2 = 32'd9;
    step();
    IN_VALID = 1'b0; FLUSH = 1'b1;
    step();
    FLUSH = 1'b0;
    chk("fl_mul_valid", OUT_VALID, 0); chk("fl_mul_ready", IN_READY, 1);
    no_stray("fl_mul_stray", 4);

    // Asynchronous reset at cycle 20 of a DIV.
    IN_VALID = 1'b1; ALU_OP = 5'd24; OP1 = 32'd1000; OP2 = 32'd7;
    step();
    IN_VALID = 1'b0;
    for (int i = 0; i < 19; i++) step();
    #2 RESET = 1'b0;
    #1;
    chk("mrst_valid", OUT_VALID, 0); chk("mrst_result", RESULT, 0);
    chk("mrst_zero", ZERO, 1); chk("mrst_sign", SIGN_BIT, 0);
    chk("mrst_sltu", SLTU_BIT, 0); chk("mrst_ready", IN_READY, 1);
    step(); step();
    RESET = 1'b1;
    no_stray("mrst_stray", 40);
    run_op("post_rst", 5'd0, 32'd5, 32'd7, 32'd12, 1);

    // Random ops against the model, with occasional idle gaps to check the pulse width.
    for (int n = 0; n < 150; n++) begin
      op = ops[$urandom_range(0, 19)];
      a = pick_operand();
      b = pick_operand();
      model(op, a, b, r, lat);
      run_op($sformatf("rnd%0d_op%0d", n, op), op, a, b, r, lat);
      if ($urandom_range(0, 3) == 0) begin
        step();
        chk($sformatf("rnd%0d_pulse", n), OUT_VALID, 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
